// File: rtl/alu_pkg.sv
// Shared character codes, controller states and sizing helpers for the RPN
// calculator ALU.
package alu_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_E     = 8'h45;

    typedef enum logic [1:0] {IDLE, EXEC, CONVERT, EMIT} alu_state_e;

    // Decimal digits needed for magnitudes up to 2**w (30103/100000 ~ log10(2)).
    function automatic int dec_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/alu_bin2dec.sv
// Iterative shift-add-3 binary to BCD converter; done pulses exactly DATA_W+1
// cycles after start, with sign and BCD magnitude held until the next start.
module alu_bin2dec
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NDIG   = dec_digits(DATA_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_value,
    output logic                o_done,
    output logic                o_neg,
    output logic [4*NDIG-1:0]   o_bcd
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_mag;
    logic [CW-1:0]     r_cnt;
    logic [4*NDIG-1:0] r_bcd;
    logic [4*NDIG-1:0] w_adj;
    logic              r_neg;
    logic              r_done;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag  <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_neg <= i_value[DATA_W-1];
                // Unsigned view of the negated value covers the most negative input.
                r_mag <= i_value[DATA_W-1] ? -i_value : i_value;
                r_bcd <= '0;
                r_cnt <= CW'(DATA_W);
            end else if (r_cnt != '0) begin
                r_bcd <= {w_adj[4*NDIG-2:0], r_mag[DATA_W-1]};
                r_mag <= {r_mag[DATA_W-2:0], 1'b0};
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1))
                    r_done <= 1'b1;
            end
        end
    end

    assign o_done = r_done;
    assign o_neg  = r_neg;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/alu.sv
// Character-driven RPN calculator: digits push, + - * / combine the top two
// entries, '=' prints the top of stack as decimal ASCII followed by newline.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_stb,
    input  logic [0:7] in_char,
    output logic       in_ack,
    output logic       out_stb,
    output logic [0:7] out_char,
    input  logic       out_ack
);

    localparam int NDIG = dec_digits(DATA_W);
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic signed [DATA_W-1:0] r_stack [STACK_DEPTH];
    logic [SPW-1:0]  r_sp;
    logic            r_err;
    alu_state_e      r_state;
    logic [7:0]      r_char;
    logic            r_start;
    logic            r_show_err;
    logic [DW-1:0]   r_idx;
    logic            r_more;
    logic            r_in_ack;
    logic            r_out_stb;
    logic [7:0]      r_out_char;

    logic [IW-1:0]            w_ip, w_i1, w_i2;
    logic signed [DATA_W-1:0] w_top, w_sec, w_res, w_q;
    logic signed [DATA_W:0]   w_a, w_b;
    logic                     w_is_digit, w_is_op;
    logic                     w_done, w_neg;
    logic [4*NDIG-1:0]        w_bcd;
    logic [DW-1:0]            w_msd;
    logic [3:0]               w_nib_msd, w_nib_idx;

    assign w_ip  = IW'(r_sp);
    assign w_i1  = IW'(r_sp - SPW'(1));
    assign w_i2  = IW'(r_sp - SPW'(2));
    assign w_top = r_stack[w_i1];
    assign w_sec = r_stack[w_i2];

    assign w_is_digit = (r_char >= CH_0) && (r_char <= CH_9);
    assign w_is_op    = r_char inside {CH_PLUS, CH_MINUS, CH_MUL, CH_DIV};

    // One extra bit keeps most-negative / -1 well defined before wrapping.
    assign w_a = {w_sec[DATA_W-1], w_sec};
    assign w_b = {w_top[DATA_W-1], w_top};
    assign w_q = DATA_W'(w_a / w_b);

    always_comb begin
        w_res = '0;
        case (r_char)
            CH_PLUS:  w_res = w_sec + w_top;
            CH_MINUS: w_res = w_sec - w_top;
            CH_MUL:   w_res = w_sec * w_top;
            CH_DIV:   w_res = w_q;
            default:  w_res = '0;
        endcase
    end

    alu_bin2dec #(.DATA_W(DATA_W), .NDIG(NDIG)) u_b2d (
        .clk     (clk),
        .reset   (reset),
        .i_start (r_start),
        .i_value (w_top),
        .o_done  (w_done),
        .o_neg   (w_neg),
        .o_bcd   (w_bcd)
    );

    always_comb begin
        w_msd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0)
                w_msd = DW'(i);
        end
    end

    assign w_nib_msd = w_bcd[4*w_msd +: 4];
    assign w_nib_idx = w_bcd[4*r_idx +: 4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sp       <= '0;
            r_err      <= 1'b0;
            r_char     <= '0;
            r_start    <= 1'b0;
            r_show_err <= 1'b0;
            r_idx      <= '0;
            r_more     <= 1'b0;
            r_in_ack   <= 1'b0;
            r_out_stb  <= 1'b0;
            r_out_char <= '0;
        end else begin
            r_in_ack <= 1'b0;
            r_start  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_stb) begin
                        r_char   <= in_char;
                        r_in_ack <= 1'b1;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_state <= IDLE;
                    if (w_is_digit) begin
                        if (r_sp == SPW'(STACK_DEPTH)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_stack[w_ip] <= DATA_W'(r_char[3:0]);
                            r_sp          <= r_sp + SPW'(1);
                        end
                    end else if (w_is_op) begin
                        if (r_sp < SPW'(2) || (r_char == CH_DIV && w_top == '0)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_stack[w_i2] <= w_res;
                            r_sp          <= r_sp - SPW'(1);
                        end
                    end else if (r_char == CH_EQ) begin
                        r_state <= CONVERT;
                        if (r_err || r_sp == '0) begin
                            r_show_err <= 1'b1;
                            r_err      <= 1'b0;
                            r_sp       <= '0;
                        end else begin
                            r_show_err <= 1'b0;
                            r_start    <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    if (r_show_err) begin
                        r_out_char <= CH_E;
                        r_out_stb  <= 1'b1;
                        r_more     <= 1'b0;
                        r_state    <= EMIT;
                    end else if (w_done) begin
                        r_out_stb <= 1'b1;
                        r_state   <= EMIT;
                        // r_idx names the next digit still owed after the current character.
                        if (w_neg) begin
                            r_out_char <= CH_MINUS;
                            r_idx      <= w_msd;
                            r_more     <= 1'b1;
                        end else begin
                            r_out_char <= {4'h3, w_nib_msd};
                            r_idx      <= w_msd - DW'(1);
                            r_more     <= (w_msd != '0);
                        end
                    end
                end
                EMIT: begin
                    if (out_ack) begin
                        if (r_out_char == CH_NL) begin
                            r_out_stb <= 1'b0;
                            r_state   <= IDLE;
                        end else if (r_more) begin
                            r_out_char <= {4'h3, w_nib_idx};
                            r_idx      <= r_idx - DW'(1);
                            if (r_idx == '0)
                                r_more <= 1'b0;
                        end else begin
                            r_out_char <= CH_NL;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ack   = r_in_ack;
    assign out_stb  = r_out_stb;
    assign out_char = r_out_char;

endmodule

// File: tb/tb_alu.sv
// Scoreboarded bench for the RPN ALU: a queue-based reference calculator
// predicts every output character; a monitor with random backpressure checks them.
module tb_alu;

    localparam int DW = 16;
    localparam int SD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_stb;
    logic [0:7] in_char;
    logic       in_ack;
    logic       out_stb;
    logic [0:7] out_char;
    logic       out_ack;

    always #5 clk = ~clk;

    alu #(.DATA_W(DW), .STACK_DEPTH(SD)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_stb   (in_stb),
        .in_char  (in_char),
        .in_ack   (in_ack),
        .out_stb  (out_stb),
        .out_char (out_char),
        .out_ack  (out_ack)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         stk[$];
    bit         m_err = 1'b0;
    bit         hold_ack = 1'b1;
    bit         prev_wait = 1'b0;
    logic [7:0] last_char;

    logic [7:0] ops[4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    logic [7:0] ign[5] = '{8'h20, 8'h28, 8'h29, 8'h78, 8'h41};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int wrap(input longint v);
        longint m;
        m = v & ((64'd1 << DW) - 1);
        if (m >= (64'd1 << (DW - 1))) m = m - (64'd1 << DW);
        return int'(m);
    endfunction

    // Reference calculator working on plain integers and strings.
    task automatic model(input logic [7:0] c);
        int     a, b;
        longint r;
        string  s;
        if (c >= "0" && c <= "9") begin
            if (stk.size() == SD) m_err = 1'b1;
            else stk.push_back(int'(c) - 48);
        end else if (c inside {"+", "-", "*", "/"}) begin
            if (stk.size() < 2) begin
                m_err = 1'b1;
            end else begin
                b = stk[$];
                a = stk[$-1];
                if (c == "/" && b == 0) begin
                    m_err = 1'b1;
                end else begin
                    case (c)
                        "+":     r = longint'(a) + b;
                        "-":     r = longint'(a) - b;
                        "*":     r = longint'(a) * b;
                        default: r = longint'(a) / b;
                    endcase
                    void'(stk.pop_back());
                    void'(stk.pop_back());
                    stk.push_back(wrap(r));
                end
            end
        end else if (c == "=") begin
            if (m_err || stk.size() == 0) begin
                exp_q.push_back(8'h45);
                exp_q.push_back(8'h0A);
                stk.delete();
                m_err = 1'b0;
            end else begin
                s = $sformatf("%0d", stk[$]);
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    task automatic send(input logic [7:0] c);
        int t = 0;
        in_char = c;
        in_stb  = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ack && t < 500);
        in_stb = 1'b0;
        if (!in_ack) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout: char %h got no ack, expected ack within 500 cycles", c);
        end else begin
            model(c);
            @(negedge clk);
            chk("ack_pulse", 8'(in_ack), 8'h00);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_stb) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || out_stb) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d chars still pending, expected 0", exp_q.size());
        end
    endtask

    // Output monitor: random backpressure, hold-stability and scoreboard compare.
    always @(negedge clk) begin
        if (hold_ack || !out_stb) begin
            out_ack   = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) chk("out_hold", out_char, last_char);
            if ($urandom_range(0, 2) != 0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL out_extra: got %h expected no output", out_char);
                end else begin
                    chk("out_char", out_char, exp_q.pop_front());
                end
                out_ack   = 1'b1;
                prev_wait = 1'b0;
            end else begin
                out_ack   = 1'b0;
                prev_wait = 1'b1;
                last_char = out_char;
            end
        end
    end

    initial begin
        int         t;
        int         len;
        int         r;
        reset   = 1'b1;
        in_stb  = 1'b0;
        in_char = '0;
        out_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ack",   8'(in_ack),  8'h00);
        chk("rst_out_stb",  8'(out_stb), 8'h00);
        chk("rst_out_char", out_char,    8'h00);
        reset    = 1'b0;
        hold_ack = 1'b0;

        send_str("21+=");
        send_str("35-=");
        send_str("99*9*=");
        send_str("70/=");
        send_str("=");
        send_str("+=");
        send_str("123456789=");
        send_str("( 3 )x=");
        drain();

        // Reset while the first output character is being held.
        hold_ack = 1'b1;
        send_str("67*=");
        t = 0;
        while (!out_stb && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("emit_first", out_char, exp_q.pop_front());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_emit_out_stb", 8'(out_stb), 8'h00);
        chk("rst_emit_in_ack",  8'(in_ack),  8'h00);
        reset = 1'b0;
        exp_q.delete();
        stk.delete();
        m_err    = 1'b0;
        hold_ack = 1'b0;
        send_str("4=");
        drain();

        repeat (60) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 5)       send(8'h30 + 8'($urandom_range(0, 9)));
                else if (r < 9)  send(ops[$urandom_range(0, 3)]);
                else             send(ign[$urandom_range(0, 4)]);
            end
            send(8'h3D);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning operand/stack word width (signed two's complement).
REQ-002 SHALL have parameter STACK_DEPTH, default 8, meaning number of operand stack entries.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_stb  input  1  input character valid.
REQ-006 SHALL have port in_char  input  8  ASCII input character, declared [0:7].
REQ-007 SHALL have port in_ack  output  1  one-cycle pulse: input character accepted.
REQ-008 SHALL have port out_stb  output  1  output character valid.
REQ-009 SHALL have port out_char  output  8  ASCII output character, declared [0:7].
REQ-010 SHALL have port out_ack  input  1  consumer has taken out_char.

Function
REQ-011 SHALL accept a character when idle and in_stb=1 at a rising edge, asserting in_ack for exactly the following cycle.
REQ-012 SHALL ignore in_stb (no ack) while processing or emitting output; held in_stb is accepted again once idle.
REQ-013 SHALL push digits '0'..'9' (8'h30..8'h39) as single-digit values 0..9; every digit is a separate operand.
REQ-014 SHALL pop two operands on '+' (2B), '-' (2D), '*' (2A), '/' (2F) and push (second-popped OP top) as DATA_W-bit wrapping result.
REQ-015 SHALL truncate division toward zero; divide by zero sets the error flag and pushes nothing.
REQ-016 SHALL set the error flag on push to a full stack or operator with fewer than two entries; stack left unchanged.
REQ-017 SHALL, on '=' (3D), emit the stack top as decimal ASCII: '-' if negative, digits most-significant first without leading zeros ("0" for zero), then 8'h0A.
REQ-018 SHALL, on '=' with error flag set or empty stack, emit 'E' (8'h45) then 8'h0A, then clear stack and error flag.
REQ-019 SHALL leave the stack unchanged after a successful '='.
REQ-020 SHALL ignore (ack, no effect) all other characters, including '(' 28, ')' 29, space.
REQ-021 SHALL hold out_stb=1 and out_char stable until out_ack=1 at a rising edge, then present the next character the following cycle or drop out_stb after 8'h0A.
REQ-022 SHALL present the first output character within 4*DATA_W cycles after '=' is acked.
REQ-023 SHALL use states IDLE, EXEC, CONVERT, EMIT; IDLE->EXEC on accept, EXEC->IDLE or CONVERT ('='), CONVERT->EMIT, EMIT->IDLE after 8'h0A acked.

Reset
REQ-024 SHALL on reset drive in_ack=0, out_stb=0, out_char=0, clear stack pointer and error flag, enter IDLE.
REQ-025 SHALL let reset abort any operation including mid-emission, dropping out_stb next cycle.

Structure
REQ-026 SHALL place ASCII constants (digits, + - * / = ( ) newline 'E') and the state enum in a shared package alu_pkg.
REQ-027 SHALL implement binary-to-decimal conversion as one sub-module, alu_bin2dec (iterative, fixed latency).

Verification
REQ-028 SHALL cover: '2','1','+','=' -> in_ack pulse per char; out_stb with '3' (33), held while out_ack=0; after ack 0A.
REQ-029 SHALL cover: '3','5','-','=' -> "-2\n" (2D,32,0A).
REQ-030 SHALL cover: '9','9','*','9','*','=' -> "729\n"; '7','0','/','=' -> "E\n" and stack cleared.
REQ-031 SHALL cover: '+' on empty stack then '=' -> "E\n"; nine digit pushes then '=' -> "E\n".
REQ-032 SHALL cover: reset asserted during EMIT -> out_stb=0, in_ack=0 next cycle; subsequent '4','=' -> "4\n".
